sw_debounce: RTL and testbench

//  Input conditioning stage between the raw board switch pins and the switch-consuming logic.

---
 rtl/sw_debounce_pkg.sv | 19 +
 rtl/sw_debounce_bit.sv | 81 ++++++++
 rtl/sw_debounce.sv | 68 ++++++
 tb/tb_sw_debounce.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_pkg
// Purpose  : Shared defaults for the switch conditioning path.
//            DEF_WIDTH            default number of switch channels
//            DEF_SYNC_STAGES      default synchroniser depth per channel
//            DEF_DEBOUNCE_CYCLES  default consecutive samples to accept a level
//            BOARD_SW_WIDTH       number of physical switches on the board
// Revision : 1.0  initial release
// ============================================================================
package sw_debounce_pkg;

  localparam int DEF_WIDTH           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 65536;
  localparam int BOARD_SW_WIDTH      = 4;

endpackage : sw_debounce_pkg
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : One switch channel: synchroniser chain, debounce counter, the
//            accepted (stable) level and one-cycle rise/fall pulses.
// Ports    : clk       in   system clock, rising edge
//            rst_n     in   asynchronous active-low reset
//            i_raw     in   raw switch pin, asynchronous to clk
//            o_stable  out  debounced level, registered
//            o_rise    out  1-cycle pulse when o_stable goes 0->1
//            o_fall    out  1-cycle pulse when o_stable goes 1->0
// Revision : 1.0  initial release
// ============================================================================
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  // Synchronised sample: the last flop of the chain.
  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // The counter tracks how many consecutive samples have disagreed with the
  // accepted level. Any agreeing sample aborts the pending change. When the
  // count reaches its last value, the new level is taken and the counter
  // restarts, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= RESET_BIT;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_stable <= w_s;
        r_cnt    <= '0;
        r_rise   <= w_s;
        r_fall   <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : Conditions raw board switches: synchronises, debounces and
//            reports clean levels plus rise/fall/change strobes.
// Ports    : clk         in   system clock, rising edge
//            rst_n       in   asynchronous active-low reset
//            sw_raw      in   [WIDTH] raw switch pins, may bounce
//            sw          out  [WIDTH] debounced level per channel
//            sw_rise     out  [WIDTH] 1-cycle pulse on accepted 0->1
//            sw_fall     out  [WIDTH] 1-cycle pulse on accepted 1->0
//            sw_changed  out  1-cycle pulse, one cycle after any rise/fall
// Revision : 1.0  initial release
// ============================================================================
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int               WIDTH           = DEF_WIDTH,
  parameter int               SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic             r_changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_BIT      (RESET_VAL[i])
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (sw_raw[i]),
      .o_stable(w_stable[i]),
      .o_rise  (w_rise[i]),
      .o_fall  (w_fall[i])
    );
  end

  // Registered so the change strobe is a clean flop output; it therefore
  // trails the per-bit strobes by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |(w_rise | w_fall);
    end
  end

  assign sw         = w_stable;
  assign sw_rise    = w_rise;
  assign sw_fall    = w_fall;
  assign sw_changed = r_changed;

endmodule : sw_debounce
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce
// Purpose  : Self-checking bench for sw_debounce (WIDTH=4, SYNC_STAGES=2,
//            DEBOUNCE_CYCLES=4). A queue-based reference model tracks the
//            synchronised sample history and accepts a new level once the
//            last DEBOUNCE_CYCLES samples all disagree with the current one.
// Revision : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

  localparam int         c_w   = 4;
  localparam int         c_sync = 2;
  localparam int         c_deb = 4;
  localparam logic [3:0] c_rv  = 4'h0;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       sw_changed;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  sw_debounce #(
    .WIDTH          (c_w),
    .SYNC_STAGES    (c_sync),
    .DEBOUNCE_CYCLES(c_deb),
    .RESET_VAL      (c_rv)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw        (sw),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_sw, m_rise, m_fall;
  logic       m_changed;
  logic [3:0] rawq[$];   // raw samples still travelling through the synchroniser
  logic [3:0] hist[$];   // most recent synchronised samples, newest last

  task automatic model_reset();
    m_sw = c_rv; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    rawq = {};
    for (int k = 0; k < c_sync; k++) rawq.push_back(c_rv);
    hist = {};
  endtask

  task automatic model_step();
    logic [3:0] s, acc;
    m_changed = |(m_rise | m_fall);
    s = rawq.pop_front();
    rawq.push_back(sw_raw);
    hist.push_back(s);
    if (hist.size() > c_deb) void'(hist.pop_front());
    acc = '0;
    for (int b = 0; b < c_w; b++) begin
      bit all_diff;
      all_diff = (hist.size() == c_deb);
      for (int k = 0; k < hist.size(); k++)
        if (hist[k][b] == m_sw[b]) all_diff = 1'b0;
      acc[b] = all_diff;
    end
    m_rise = acc & ~m_sw;
    m_fall = acc & m_sw;
    m_sw   = m_sw ^ acc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sw", {28'h0, sw}, {28'h0, m_sw});
      chk("sw_rise", {28'h0, sw_rise}, {28'h0, m_rise});
      chk("sw_fall", {28'h0, sw_fall}, {28'h0, m_fall});
      chk("sw_changed", {31'h0, sw_changed}, {31'h0, m_changed});
      chk("rise_and_fall", {28'h0, sw_rise & sw_fall}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_edges_chk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hold[4];

  initial begin
    rst_n  = 1'b1;
    sw_raw = 4'hF;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // 1. reset with raw high
    wait_edges_chk(3);
    chk("t1 reset sw", {28'h0, sw}, 32'h0);
    chk("t1 reset strobes", {23'h0, sw_rise, sw_fall, sw_changed}, 32'h0);
    #1 rst_n = 1'b1;
    wait_edges_chk(5);
    chk("t1 sw before 6", {28'h0, sw}, 32'h0);
    wait_edges_chk(1);
    chk("t1 sw at 6", {28'h0, sw}, 32'hF);
    chk("t1 rise at 6", {28'h0, sw_rise}, 32'hF);
    wait_edges_chk(1);
    chk("t1 changed", {31'h0, sw_changed}, 32'h1);

    // 2. clean rise on bit 0 from a fresh reset
    #1 rst_n = 1'b0;
    sw_raw = 4'h0;
    #1 chk("t2 async reset sw", {28'h0, sw}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk) sw_raw = 4'h1;
    wait_edges_chk(5);
    chk("t2 sw before 6", {28'h0, sw}, 32'h0);
    wait_edges_chk(1);
    chk("t2 sw at 6", {28'h0, sw}, 32'h1);
    chk("t2 rise at 6", {28'h0, sw_rise}, 32'h1);
    wait_edges_chk(1);
    chk("t2 changed", {31'h0, sw_changed}, 32'h1);
    chk("t2 rise gone", {28'h0, sw_rise}, 32'h0);

    // 3. bounce on bit 1 never accepted, then a held level is
    @(negedge clk) sw_raw = 4'h3;
    repeat (3) @(negedge clk);
    sw_raw = 4'h1;
    @(negedge clk);
    sw_raw = 4'h3;
    repeat (3) @(negedge clk);
    sw_raw = 4'h1;
    repeat (8) @(negedge clk);
    chk("t3 bounce ignored", {28'h0, sw}, 32'h1);
    sw_raw = 4'h3;
    repeat (8) @(negedge clk);
    chk("t3 held accepted", {28'h0, sw}, 32'h3);

    // 4. simultaneous changes
    sw_raw = 4'h0;
    repeat (10) @(negedge clk);
    chk("t4 cleared", {28'h0, sw}, 32'h0);
    sw_raw = 4'hA;
    wait_edges_chk(5);
    chk("t4 sw before 6", {28'h0, sw}, 32'h0);
    wait_edges_chk(1);
    chk("t4 sw A", {28'h0, sw}, 32'hA);
    chk("t4 rise A", {28'h0, sw_rise}, 32'hA);
    @(negedge clk) sw_raw = 4'h5;
    wait_edges_chk(6);
    chk("t4 sw 5", {28'h0, sw}, 32'h5);
    chk("t4 fall A", {28'h0, sw_fall}, 32'hA);
    chk("t4 rise 5", {28'h0, sw_rise}, 32'h5);

    // 5. reset in the middle of a pending change
    @(negedge clk) sw_raw = 4'h0;
    repeat (10) @(negedge clk);
    chk("t5 cleared", {28'h0, sw}, 32'h0);
    sw_raw = 4'h4;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 reset sw", {28'h0, sw}, 32'h0);
    chk("t5 reset strobes", {24'h0, sw_rise, sw_fall}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_edges_chk(5);
    chk("t5 sw before 6", {28'h0, sw}, 32'h0);
    wait_edges_chk(1);
    chk("t5 sw 4", {28'h0, sw}, 32'h4);
    chk("t5 rise 4", {28'h0, sw_rise}, 32'h4);

    // 6. randomised glitches and genuine changes on every channel
    for (int b = 0; b < c_w; b++) hold[b] = $urandom_range(1, 12);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int b = 0; b < c_w; b++) begin
        if (hold[b] == 0) begin
          sw_raw[b] = ~sw_raw[b];
          hold[b] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                 : $urandom_range(4, 12);
        end else begin
          hold[b] = hold[b] - 1;
        end
      end
    end
    repeat (20) @(negedge clk);

    cmp_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sw_debounce
`default_nettype wire
